picosoc_busmux: RTL and testbench
=================================

Name: picosoc_busmux

Overview:
- Parametrised memory-bus interconnect between one PicoRV32-style native master and NUM_SLAVES slaves. Replaces the hand-written per-peripheral select/ready/rdata muxing in the SoC top.
- Decodes each request against per-slave base/mask regions and forwards it to one slave with registered, one-transaction-at-a-time handshaking.
- Adds behaviour the old muxing lacks: decode-miss error responses, a per-transaction timeout watchdog, and sticky error capture with an interrupt.

Parameters:
- NUM_SLAVES, 4, number of slave ports (1..16).
- SLV_BASE, {32'h0300_0000, 32'h0200_0000, 32'h0010_0000, 32'h0000_0000}, packed 32*NUM_SLAVES region bases; slave i is in bits [32*i+31:32*i].
- SLV_MASK, {32'hFF00_0000, 32'hFFFF_FFF0, 32'hFFF0_0000, 32'hFFFF_FC00}, packed region masks, laid out like SLV_BASE.
- TIMEOUT_CYCLES, 255, cycles in ACTIVE before abort. Range 0..65535; 0 disables the timeout.
- ERR_RDATA, 32'hDEAD_BEEF, read data returned on an error.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- m_valid  in  1  master request
- m_ready  out  1  master completion pulse
- m_addr  in  32  master address
- m_wdata  in  32  master write data
- m_wstrb  in  4  byte strobes; 0 means read
- m_rdata  out  32  read data, valid while m_ready=1
- m_err  out  1  error flag, valid while m_ready=1
- s_valid  out  NUM_SLAVES  one-hot slave request
- s_ready  in  NUM_SLAVES  slave completion
- s_addr  out  32  latched address, broadcast to all slaves
- s_wdata  out  32  latched write data, broadcast
- s_wstrb  out  4  latched strobes, broadcast
- s_rdata  in  32*NUM_SLAVES  slave read data, packed like SLV_BASE
- err_addr  out  32  address of the most recent error
- err_count  out  8  error counter, saturates at 255
- err_clr  in  1  clears irq_buserr
- irq_buserr  out  1  sticky error interrupt

Behaviour:
- Reset (async, resetn=0): FSM=IDLE; m_ready, m_err, s_valid, irq_buserr, err_count = 0; m_rdata, s_addr, s_wdata, s_wstrb, err_addr = 0; timeout counter = 0. Reset asserted mid-transaction aborts it with no response.
- Decode: slave i hits when (m_addr & MASK_i) == BASE_i. The lowest hit index wins on overlap.
- FSM states: IDLE, ACTIVE, RESP.
- IDLE, m_valid=1:
  - Latch addr/wdata/wstrb and the selected index; clear the counter.
  - On a hit, go to ACTIVE. On a miss, set the error flag and go to RESP.
- ACTIVE:
  - s_valid[sel]=1; every other s_valid bit = 0.
  - If s_ready[sel]=1: capture s_rdata[sel] and go to RESP.
  - Else, if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: set the error flag and go to RESP. s_valid drops on that transition.
  - Else: increment the counter.
  - If ready and timeout occur in the same cycle, ready wins.
- RESP:
  - m_ready=1 for exactly one cycle.
  - m_rdata = captured data, or ERR_RDATA on error. m_err = error flag.
  - Next state is IDLE.
- Outside RESP: m_ready=0 and m_err=0. m_rdata holds its last value.
- Latency: the minimum is s_valid in cycle N+1 and m_ready in cycle N+2 after an IDLE request in cycle N (slave ready in the same cycle as s_valid). Every slave wait cycle adds 1.
- Decode miss: m_ready in cycle N+1 with m_err=1. No s_valid is asserted.
- s_ready bits are ignored unless the slave is selected and the FSM is in ACTIVE.
- m_valid is sampled only in IDLE. Deasserting m_valid mid-transaction does not cancel it. m_valid=1 in IDLE after RESP is treated as a new request.
- On any error (in the cycle RESP is entered):
  - err_addr = latched address.
  - err_count increments, saturating at 255.
  - irq_buserr is set.
- err_clr=1 clears irq_buserr. If set and clear happen in the same cycle, set wins.
- Writes use the same flow as reads; m_rdata on a successful write is s_rdata[sel] as sampled.

Test Plan:
- Read at 0x0000_0010; slave 0 drives s_ready with s_rdata0=0x1234_5678 in the first s_valid cycle -> s_valid=4'b0001 in cycle 1, m_ready=1 in cycle 2, m_rdata=0x1234_5678, m_err=0.
- Write 0xA5A5_0000 with wstrb=4'hF to 0x0200_0008; slave 2 waits 3 cycles -> s_valid=4'b0100 for 4 cycles, s_wdata=0xA5A5_0000, s_wstrb=4'hF, m_ready in cycle 5.
- Read at 0x0100_0000 (no region matches) -> m_ready in cycle 1, m_err=1, m_rdata=0xDEAD_BEEF, err_addr=0x0100_0000, err_count=1, irq_buserr=1.
- Read at 0x0300_0000 with slave 3 never ready -> s_valid[3] high for exactly 255 cycles, then m_ready with m_err=1 and m_rdata=0xDEAD_BEEF. Repeat with s_ready arriving in cycle 255 -> no error.
- Pulse err_clr in the same cycle as a new error -> irq_buserr stays 1. Pulse it alone the next cycle -> irq_buserr=0 while err_count is unchanged. After 300 errors -> err_count=255.
- Assert resetn=0 while in ACTIVE -> s_valid=0 and m_ready=0 immediately (asynchronously). After release, a fresh read completes normally.

Source files
------------

// File: rtl/picosoc_busmux.sv
// Address-decoded bus mux between one PicoRV32-style master and NUM_SLAVES slaves, with a miss/timeout error path.
// A hit responds at N+2 plus one cycle per slave wait state, a miss at N+1. One transaction at a time; slaves stall through s_ready.
module picosoc_busmux #(
  parameter int                        NUM_SLAVES     = 4,
  parameter logic [32*NUM_SLAVES-1:0]  SLV_BASE       = {32'h0300_0000, 32'h0200_0000, 32'h0010_0000, 32'h0000_0000},
  parameter logic [32*NUM_SLAVES-1:0]  SLV_MASK       = {32'hFF00_0000, 32'hFFFF_FFF0, 32'hFFF0_0000, 32'hFFFF_FC00},
  parameter int                        TIMEOUT_CYCLES = 255,
  parameter logic [31:0]               ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         m_valid,
  output logic                         m_ready,
  input  logic [31:0]                  m_addr,
  input  logic [31:0]                  m_wdata,
  input  logic [3:0]                   m_wstrb,
  output logic [31:0]                  m_rdata,
  output logic                         m_err,
  output logic [NUM_SLAVES-1:0]        s_valid,
  input  logic [NUM_SLAVES-1:0]        s_ready,
  output logic [31:0]                  s_addr,
  output logic [31:0]                  s_wdata,
  output logic [3:0]                   s_wstrb,
  input  logic [32*NUM_SLAVES-1:0]     s_rdata,
  output logic [31:0]                  err_addr,
  output logic [7:0]                   err_count,
  input  logic                         err_clr,
  output logic                         irq_buserr
);

  localparam int          SEL_W   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

  state_t                  state;
  logic [SEL_W-1:0]        sel;
  logic [15:0]             cnt;

  logic                    hit;
  logic [SEL_W-1:0]        hit_idx;
  logic [NUM_SLAVES-1:0]   hit_onehot;
  logic                    sel_ready;
  logic [31:0]             sel_rdata;
  logic                    timeout_hit;
  logic                    err_set;
  logic [31:0]             err_at;

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    hit_onehot = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((m_addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
        hit        = 1'b1;
        hit_idx    = SEL_W'(i);
        hit_onehot = '0;
        hit_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (SEL_W'(i) == sel) begin
        sel_ready = s_ready[i];
        sel_rdata = s_rdata[32*i +: 32];
      end
    end
  end

  always_comb begin
    timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST);
    err_set     = ((state == IDLE) && m_valid && !hit) ||
                  ((state == ACTIVE) && !sel_ready && timeout_hit);
    err_at      = (state == IDLE) ? m_addr : s_addr;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      sel        <= '0;
      cnt        <= '0;
      m_ready    <= 1'b0;
      m_err      <= 1'b0;
      m_rdata    <= '0;
      s_valid    <= '0;
      s_addr     <= '0;
      s_wdata    <= '0;
      s_wstrb    <= '0;
      err_addr   <= '0;
      err_count  <= '0;
      irq_buserr <= 1'b0;
    end else begin
      m_ready <= 1'b0;
      m_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (m_valid) begin
            s_addr  <= m_addr;
            s_wdata <= m_wdata;
            s_wstrb <= m_wstrb;
            sel     <= hit_idx;
            cnt     <= '0;
            if (hit) begin
              s_valid <= hit_onehot;
              state   <= ACTIVE;
            end else begin
              m_ready <= 1'b1;
              m_err   <= 1'b1;
              m_rdata <= ERR_RDATA;
              state   <= RESP;
            end
          end
        end
        ACTIVE: begin
          // Ready is tested first so a completion in the last allowed cycle is not aborted.
          if (sel_ready) begin
            s_valid <= '0;
            m_ready <= 1'b1;
            m_rdata <= sel_rdata;
            state   <= RESP;
          end else if (timeout_hit) begin
            s_valid <= '0;
            m_ready <= 1'b1;
            m_err   <= 1'b1;
            m_rdata <= ERR_RDATA;
            state   <= RESP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (err_set) begin
        err_addr   <= err_at;
        irq_buserr <= 1'b1;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end else if (err_clr) begin
        irq_buserr <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_picosoc_busmux.sv
// Directed bench for picosoc_busmux: hit/miss/timeout paths, error capture and async reset.
module tb_picosoc_busmux;

  logic         clk = 1'b0;
  logic         resetn;
  logic         m_valid;
  logic         m_ready;
  logic [31:0]  m_addr;
  logic [31:0]  m_wdata;
  logic [3:0]   m_wstrb;
  logic [31:0]  m_rdata;
  logic         m_err;
  logic [3:0]   s_valid;
  logic [3:0]   s_ready;
  logic [31:0]  s_addr;
  logic [31:0]  s_wdata;
  logic [3:0]   s_wstrb;
  logic [127:0] s_rdata;
  logic [31:0]  err_addr;
  logic [7:0]   err_count;
  logic         err_clr;
  logic         irq_buserr;

  int n_checks = 0;
  int n_fails  = 0;

  picosoc_busmux dut (
    .clk(clk), .resetn(resetn),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_rdata(m_rdata), .m_err(m_err),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_rdata(s_rdata),
    .err_addr(err_addr), .err_count(err_count), .err_clr(err_clr), .irq_buserr(irq_buserr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change and outputs are sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int cnt;

  initial begin
    resetn  = 1'b0;
    m_valid = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_wstrb = '0;
    s_ready = '0;
    s_rdata = '0;
    err_clr = 1'b0;
    #12;
    check("rst_m_ready", 32'(m_ready), 32'd0);
    check("rst_s_valid", 32'(s_valid), 32'd0);
    check("rst_m_rdata", m_rdata, 32'h0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_irq", 32'(irq_buserr), 32'd0);
    resetn = 1'b1;
    step();

    // Zero-wait read from slave 0
    m_valid = 1'b1; m_addr = 32'h0000_0010; m_wstrb = 4'h0;
    step();
    m_valid = 1'b0;
    check("rd0_s_valid", 32'(s_valid), 32'h1);
    check("rd0_no_ready_yet", 32'(m_ready), 32'd0);
    check("rd0_s_addr", s_addr, 32'h0000_0010);
    s_ready = 4'b0001; s_rdata[31:0] = 32'h1234_5678;
    step();
    s_ready = '0;
    check("rd0_m_ready", 32'(m_ready), 32'd1);
    check("rd0_m_rdata", m_rdata, 32'h1234_5678);
    check("rd0_m_err", 32'(m_err), 32'd0);
    check("rd0_s_valid_drop", 32'(s_valid), 32'd0);
    step();
    check("rd0_ready_pulse", 32'(m_ready), 32'd0);
    check("rd0_rdata_hold", m_rdata, 32'h1234_5678);

    // Write to slave 2 with three wait states
    m_valid = 1'b1; m_addr = 32'h0200_0008; m_wdata = 32'hA5A5_0000; m_wstrb = 4'hF;
    s_rdata[95:64] = 32'h0BAD_F00D;
    step();
    m_valid = 1'b0; m_wdata = '0; m_wstrb = '0;
    cnt = 0;
    for (int c = 1; c <= 4; c++) begin
      if (s_valid == 4'b0100) cnt++;
      if (c == 4) s_ready = 4'b0100;
      step();
    end
    s_ready = '0;
    check("wr2_s_valid_cycles", 32'(cnt), 32'd4);
    check("wr2_s_wdata", s_wdata, 32'hA5A5_0000);
    check("wr2_s_wstrb", 32'(s_wstrb), 32'hF);
    check("wr2_m_ready_c5", 32'(m_ready), 32'd1);
    check("wr2_m_rdata", m_rdata, 32'h0BAD_F00D);
    check("wr2_m_err", 32'(m_err), 32'd0);
    step();

    // Decode miss
    m_valid = 1'b1; m_addr = 32'h0100_0000;
    step();
    m_valid = 1'b0;
    check("miss_m_ready", 32'(m_ready), 32'd1);
    check("miss_m_err", 32'(m_err), 32'd1);
    check("miss_m_rdata", m_rdata, 32'hDEAD_BEEF);
    check("miss_s_valid", 32'(s_valid), 32'd0);
    check("miss_err_addr", err_addr, 32'h0100_0000);
    check("miss_err_count", 32'(err_count), 32'd1);
    check("miss_irq", 32'(irq_buserr), 32'd1);
    step();

    // Timeout on slave 3
    m_valid = 1'b1; m_addr = 32'h0300_0000;
    step();
    m_valid = 1'b0;
    cnt = 0;
    for (int c = 0; c < 400 && s_valid[3]; c++) begin
      cnt++;
      step();
    end
    check("to_s_valid_cycles", 32'(cnt), 32'd255);
    check("to_m_ready", 32'(m_ready), 32'd1);
    check("to_m_err", 32'(m_err), 32'd1);
    check("to_m_rdata", m_rdata, 32'hDEAD_BEEF);
    check("to_err_count", 32'(err_count), 32'd2);
    check("to_err_addr", err_addr, 32'h0300_0000);
    step();

    // Ready arriving in the 255th cycle beats the timeout
    m_valid = 1'b1; m_addr = 32'h0300_0004;
    step();
    m_valid = 1'b0;
    repeat (254) step();
    check("late_s_valid_c255", 32'(s_valid), 32'h8);
    s_ready = 4'b1000; s_rdata[127:96] = 32'hCAFE_0003;
    step();
    s_ready = '0;
    check("late_m_ready", 32'(m_ready), 32'd1);
    check("late_m_err", 32'(m_err), 32'd0);
    check("late_m_rdata", m_rdata, 32'hCAFE_0003);
    check("late_err_count", 32'(err_count), 32'd2);
    step();

    // Interrupt clear, including clear colliding with a new error
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("clr_irq", 32'(irq_buserr), 32'd0);
    check("clr_count_kept", 32'(err_count), 32'd2);
    m_valid = 1'b1; m_addr = 32'h0100_0000; err_clr = 1'b1;
    step();
    m_valid = 1'b0;
    check("set_wins_irq", 32'(irq_buserr), 32'd1);
    check("set_wins_count", 32'(err_count), 32'd3);
    step();
    err_clr = 1'b0;
    check("clr2_irq", 32'(irq_buserr), 32'd0);
    check("clr2_count", 32'(err_count), 32'd3);

    // Saturation: 297 more misses brings the total to 300
    for (int e = 0; e < 297; e++) begin
      m_valid = 1'b1; m_addr = 32'h0400_0000 + 32'(e);
      step();
      m_valid = 1'b0;
      step();
    end
    check("sat_err_count", 32'(err_count), 32'd255);
    check("sat_err_addr", err_addr, 32'h0400_0128);

    // Async reset in ACTIVE
    m_valid = 1'b1; m_addr = 32'h0000_0020;
    step();
    m_valid = 1'b0;
    check("arst_pre_s_valid", 32'(s_valid), 32'h1);
    #2 resetn = 1'b0;
    #1;
    check("arst_s_valid", 32'(s_valid), 32'd0);
    check("arst_m_ready", 32'(m_ready), 32'd0);
    check("arst_err_count", 32'(err_count), 32'd0);
    check("arst_irq", 32'(irq_buserr), 32'd0);
    step();
    resetn = 1'b1;
    step();
    m_valid = 1'b1; m_addr = 32'h0010_0004;
    step();
    m_valid = 1'b0;
    check("post_s_valid", 32'(s_valid), 32'h2);
    s_ready = 4'b0010; s_rdata[63:32] = 32'h5555_AAAA;
    step();
    s_ready = '0;
    check("post_m_ready", 32'(m_ready), 32'd1);
    check("post_m_rdata", m_rdata, 32'h5555_AAAA);
    check("post_m_err", 32'(m_err), 32'd0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
